ex_multicycle: RTL and testbench

EX_MULTICYCLE -- requirements
Module: ex_multicycle

---
 rtl/ex_multicycle_pkg.sv | 33 +++
 rtl/ex_multicycle_if.sv | 35 +++
 rtl/div_iter.sv | 137 +++++++++++++
 rtl/ex_multicycle.sv | 102 ++++++++++
 tb/tb_ex_multicycle.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/ex_multicycle_pkg.sv
// Shared opcodes, result-class codes and divider FSM encoding for the
// multicycle execute stage.
package ex_multicycle_pkg;

    localparam int ALUOP_W  = 8;
    localparam int ALUSEL_W = 3;

    localparam logic [ALUOP_W-1:0] EXE_NOP_OP  = 8'b0000_0000;
    localparam logic [ALUOP_W-1:0] EXE_AND_OP  = 8'b0010_0100;
    localparam logic [ALUOP_W-1:0] EXE_OR_OP   = 8'b0010_0101;
    localparam logic [ALUOP_W-1:0] EXE_XOR_OP  = 8'b0010_0110;
    localparam logic [ALUOP_W-1:0] EXE_NOR_OP  = 8'b0010_0111;
    localparam logic [ALUOP_W-1:0] EXE_SLL_OP  = 8'b0111_1100;
    localparam logic [ALUOP_W-1:0] EXE_SRL_OP  = 8'b0000_0010;
    localparam logic [ALUOP_W-1:0] EXE_SRA_OP  = 8'b0000_0011;
    localparam logic [ALUOP_W-1:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [ALUOP_W-1:0] EXE_DIVU_OP = 8'b0001_1011;

    localparam logic [ALUSEL_W-1:0] EXE_RES_NOP   = 3'b000;
    localparam logic [ALUSEL_W-1:0] EXE_RES_LOGIC = 3'b001;
    localparam logic [ALUSEL_W-1:0] EXE_RES_SHIFT = 3'b010;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_BUSY = 2'b01,
        DIV_DONE = 2'b10
    } div_state_t;

    function automatic logic is_div_op(input logic [ALUOP_W-1:0] op);
        return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
    endfunction

endpackage

// File: rtl/ex_multicycle_if.sv
// Execute-stage bundle: decoded operation in, GPR and HI/LO writeback plus
// stall request out.
interface ex_multicycle_if
    import ex_multicycle_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
);

    logic [ALUOP_W-1:0]    aluop_i;
    logic [ALUSEL_W-1:0]   alusel_i;
    logic [DATA_W-1:0]     reg1_i;
    logic [DATA_W-1:0]     reg2_i;
    logic [REG_ADDR_W-1:0] wd_i;
    logic                  wreg_i;
    logic                  flush_i;
    logic [REG_ADDR_W-1:0] wd_o;
    logic                  wreg_o;
    logic [DATA_W-1:0]     wdata_o;
    logic [DATA_W-1:0]     hi_o;
    logic [DATA_W-1:0]     lo_o;
    logic                  whilo_o;
    logic                  stallreq_o;

    modport master (
        output aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, flush_i,
        input  wd_o, wreg_o, wdata_o, hi_o, lo_o, whilo_o, stallreq_o
    );

    modport slave (
        input  aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, flush_i,
        output wd_o, wreg_o, wdata_o, hi_o, lo_o, whilo_o, stallreq_o
    );

endinterface

// File: rtl/div_iter.sv
// Radix-2 restoring divider: one quotient bit per cycle on operand
// magnitudes, sign fix-up applied on the way out.
module div_iter
    import ex_multicycle_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              is_signed,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    input  logic              flush,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    function automatic logic [DATA_W-1:0] neg2(input logic [DATA_W-1:0] v);
        return ~v + {{(DATA_W-1){1'b0}}, 1'b1};
    endfunction

    div_state_t        state_r;
    div_state_t        state_nxt_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [DATA_W-1:0] dvd_r;
    logic [DATA_W-1:0] dvs_r;
    logic [DATA_W-1:0] rem_r;
    logic              neg_q_r;
    logic              neg_r_r;

    logic              dvd_neg_s;
    logic              dvs_neg_s;
    logic [DATA_W-1:0] dvd_mag_s;
    logic [DATA_W-1:0] dvs_mag_s;
    logic [DATA_W:0]   trial_s;
    logic [DATA_W:0]   diff_s;
    logic              fits_s;

    // Operand magnitudes and the trial subtraction of the current step
    always_comb begin
        dvd_neg_s = is_signed & dividend[DATA_W-1];
        dvs_neg_s = is_signed & divisor[DATA_W-1];
        dvd_mag_s = dvd_neg_s ? neg2(dividend) : dividend;
        dvs_mag_s = dvs_neg_s ? neg2(divisor) : divisor;
        trial_s   = {rem_r, dvd_r[DATA_W-1]};
        diff_s    = trial_s - {1'b0, dvs_r};
        fits_s    = (trial_s >= {1'b0, dvs_r});
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= DIV_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; flush wins from every state
    always_comb begin
        state_nxt_s = DIV_IDLE;
        if (flush) begin
            state_nxt_s = DIV_IDLE;
        end else begin
            case (state_r)
                DIV_IDLE: state_nxt_s = start ? DIV_BUSY : DIV_IDLE;
                DIV_BUSY: state_nxt_s = (cnt_r == CNT_LAST) ? DIV_DONE : DIV_BUSY;
                DIV_DONE: state_nxt_s = DIV_IDLE;
                default:  state_nxt_s = DIV_IDLE;
            endcase
        end
    end

    // FSM outputs; busy covers the launch cycle so the pipeline freezes at once
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        if (flush) begin
            busy = 1'b0;
            done = 1'b0;
        end else begin
            case (state_r)
                DIV_IDLE: busy = start;
                DIV_BUSY: busy = 1'b1;
                DIV_DONE: done = 1'b1;
                default:  busy = 1'b0;
            endcase
        end
    end

    // Datapath: operand capture on launch, one shift/subtract per BUSY cycle.
    // A zero divisor yields all-ones naturally, so its quotient is never negated.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r   <= {CNT_W{1'b0}};
            dvd_r   <= {DATA_W{1'b0}};
            dvs_r   <= {DATA_W{1'b0}};
            rem_r   <= {DATA_W{1'b0}};
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
        end else begin
            case (state_r)
                DIV_IDLE: begin
                    if (start && !flush) begin
                        cnt_r   <= {CNT_W{1'b0}};
                        dvd_r   <= dvd_mag_s;
                        dvs_r   <= dvs_mag_s;
                        rem_r   <= {DATA_W{1'b0}};
                        neg_q_r <= (dvd_neg_s ^ dvs_neg_s) & (divisor != {DATA_W{1'b0}});
                        neg_r_r <= dvd_neg_s;
                    end
                end
                DIV_BUSY: begin
                    if (!flush) begin
                        rem_r <= fits_s ? diff_s[DATA_W-1:0] : trial_s[DATA_W-1:0];
                        dvd_r <= {dvd_r[DATA_W-2:0], fits_s};
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    assign quotient  = neg_q_r ? neg2(dvd_r) : dvd_r;
    assign remainder = neg_r_r ? neg2(rem_r) : rem_r;

endmodule

// File: rtl/ex_multicycle.sv
// Execute stage: single-cycle logic/shift results plus an iterative
// DIV/DIVU unit that stalls the pipeline and writes HI/LO when finished.
module ex_multicycle
    import ex_multicycle_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic           clk,
    input  logic           rst,
    ex_multicycle_if.slave bus
);

    localparam int SHAMT_W = $clog2(DATA_W);

    logic [SHAMT_W-1:0] shamt_s;
    logic [DATA_W-1:0]  logic_res_s;
    logic [DATA_W-1:0]  shift_res_s;
    logic [DATA_W-1:0]  sel_res_s;
    logic               div_start_s;
    logic               div_signed_s;
    logic               div_busy_s;
    logic               div_done_s;
    logic [DATA_W-1:0]  quot_s;
    logic [DATA_W-1:0]  rem_s;

    assign shamt_s      = bus.reg1_i[SHAMT_W-1:0];
    assign div_start_s  = is_div_op(bus.aluop_i);
    assign div_signed_s = (bus.aluop_i == EXE_DIV_OP);

    // Bitwise logic results
    always_comb begin
        logic_res_s = {DATA_W{1'b0}};
        case (bus.aluop_i)
            EXE_OR_OP:  logic_res_s = bus.reg1_i | bus.reg2_i;
            EXE_AND_OP: logic_res_s = bus.reg1_i & bus.reg2_i;
            EXE_NOR_OP: logic_res_s = ~(bus.reg1_i | bus.reg2_i);
            EXE_XOR_OP: logic_res_s = bus.reg1_i ^ bus.reg2_i;
            default:    logic_res_s = {DATA_W{1'b0}};
        endcase
    end

    // Shifts of reg2 by the low bits of reg1
    always_comb begin
        shift_res_s = {DATA_W{1'b0}};
        case (bus.aluop_i)
            EXE_SLL_OP: shift_res_s = bus.reg2_i << shamt_s;
            EXE_SRL_OP: shift_res_s = bus.reg2_i >> shamt_s;
            EXE_SRA_OP: shift_res_s = $unsigned($signed(bus.reg2_i) >>> shamt_s);
            default:    shift_res_s = {DATA_W{1'b0}};
        endcase
    end

    // GPR write-data select by result class
    always_comb begin
        sel_res_s = {DATA_W{1'b0}};
        case (bus.alusel_i)
            EXE_RES_LOGIC: sel_res_s = logic_res_s;
            EXE_RES_SHIFT: sel_res_s = shift_res_s;
            default:       sel_res_s = {DATA_W{1'b0}};
        endcase
    end

    div_iter #(
        .DATA_W (DATA_W)
    ) u_div_iter (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start_s),
        .is_signed (div_signed_s),
        .dividend  (bus.reg1_i),
        .divisor   (bus.reg2_i),
        .flush     (bus.flush_i),
        .busy      (div_busy_s),
        .done      (div_done_s),
        .quotient  (quot_s),
        .remainder (rem_s)
    );

    // Output drive; everything reads zero while reset is held
    always_comb begin
        bus.wd_o       = {REG_ADDR_W{1'b0}};
        bus.wreg_o     = 1'b0;
        bus.wdata_o    = {DATA_W{1'b0}};
        bus.whilo_o    = 1'b0;
        bus.hi_o       = {DATA_W{1'b0}};
        bus.lo_o       = {DATA_W{1'b0}};
        bus.stallreq_o = 1'b0;
        if (!rst) begin
            bus.stallreq_o = 1'b0;
        end else begin
            bus.wd_o       = bus.wd_i;
            bus.wreg_o     = bus.wreg_i;
            bus.wdata_o    = sel_res_s;
            bus.stallreq_o = div_busy_s;
            bus.whilo_o    = div_done_s;
            bus.hi_o       = div_done_s ? rem_s  : {DATA_W{1'b0}};
            bus.lo_o       = div_done_s ? quot_s : {DATA_W{1'b0}};
        end
    end

endmodule

// File: tb/tb_ex_multicycle.sv
// Directed bench for ex_multicycle: logic/shift paths, signed/unsigned
// division corner cases, flush, reset abort, and a 16-bit instance.
module tb_ex_multicycle;
    import ex_multicycle_pkg::*;

    logic clk;
    logic rst;
    int   vec_cnt = 0;
    int   err_cnt = 0;

    ex_multicycle_if #(.DATA_W(32), .REG_ADDR_W(5)) bus32 ();
    ex_multicycle_if #(.DATA_W(16), .REG_ADDR_W(5)) bus16 ();

    ex_multicycle #(.DATA_W(32), .REG_ADDR_W(5)) dut32 (
        .clk (clk),
        .rst (rst),
        .bus (bus32)
    );

    ex_multicycle #(.DATA_W(16), .REG_ADDR_W(5)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic get_stall(input bit w16);
        return w16 ? bus16.stallreq_o : bus32.stallreq_o;
    endfunction

    function automatic logic get_whilo(input bit w16);
        return w16 ? bus16.whilo_o : bus32.whilo_o;
    endfunction

    function automatic logic [63:0] get_lo(input bit w16);
        return w16 ? {48'h0, bus16.lo_o} : {32'h0, bus32.lo_o};
    endfunction

    function automatic logic [63:0] get_hi(input bit w16);
        return w16 ? {48'h0, bus16.hi_o} : {32'h0, bus32.hi_o};
    endfunction

    task automatic drive(input bit w16, input logic [7:0] op, input logic [2:0] sel,
                         input logic [31:0] a, input logic [31:0] b);
        if (w16) begin
            bus16.aluop_i  = op;
            bus16.alusel_i = sel;
            bus16.reg1_i   = a[15:0];
            bus16.reg2_i   = b[15:0];
        end else begin
            bus32.aluop_i  = op;
            bus32.alusel_i = sel;
            bus32.reg1_i   = a;
            bus32.reg2_i   = b;
        end
    endtask

    task automatic apply(input bit w16, input logic [7:0] op, input logic [2:0] sel,
                         input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        drive(w16, op, sel, a, b);
        #1;
    endtask

    task automatic wait_div(input bit w16, input int exp_stall, input logic [63:0] exp_lo,
                            input logic [63:0] exp_hi, input string tag);
        int stalls;
        bit seen;
        stalls = 0;
        seen   = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (get_whilo(w16)) begin
                seen = 1'b1;
                break;
            end
            if (get_stall(w16)) stalls++;
            @(negedge clk);
            #1;
        end
        check({tag, "_pulse"}, 64'(seen), 64'd1);
        check({tag, "_stallcycles"}, 64'(stalls), 64'(exp_stall));
        check({tag, "_lo"}, get_lo(w16), exp_lo);
        check({tag, "_hi"}, get_hi(w16), exp_hi);
        check({tag, "_stall_done"}, 64'(get_stall(w16)), 64'd0);
    endtask

    task automatic end_div(input bit w16, input string tag);
        apply(w16, EXE_NOP_OP, EXE_RES_NOP, 32'h0, 32'h0);
        check({tag, "_single_pulse"}, 64'(get_whilo(w16)), 64'd0);
        check({tag, "_lo_idle"}, get_lo(w16), 64'd0);
    endtask

    initial begin
        int pulses;
        rst = 1'b0;
        drive(1'b0, EXE_OR_OP, EXE_RES_LOGIC, 32'h0000_FFFF, 32'hFF00_0000);
        drive(1'b1, EXE_NOP_OP, EXE_RES_NOP, 32'h0, 32'h0);
        bus32.wd_i = 5'd9; bus32.wreg_i = 1'b1; bus32.flush_i = 1'b0;
        bus16.wd_i = 5'd0; bus16.wreg_i = 1'b0; bus16.flush_i = 1'b0;
        #2;
        check("rst_wdata", {32'h0, bus32.wdata_o}, 64'd0);
        check("rst_wd", {59'h0, bus32.wd_o}, 64'd0);
        check("rst_wreg", 64'(bus32.wreg_o), 64'd0);
        check("rst_hilo", get_hi(1'b0) | get_lo(1'b0), 64'd0);
        check("rst_whilo", 64'(bus32.whilo_o), 64'd0);
        drive(1'b0, EXE_DIV_OP, EXE_RES_NOP, 32'd7, 32'd2);
        #1;
        check("rst_stall", 64'(bus32.stallreq_o), 64'd0);
        @(negedge clk);
        drive(1'b0, EXE_NOP_OP, EXE_RES_NOP, 32'h0, 32'h0);
        rst = 1'b1;

        // Single-cycle logic and shift paths
        apply(1'b0, EXE_OR_OP, EXE_RES_LOGIC, 32'h0000_FFFF, 32'hFF00_0000);
        check("or", {32'h0, bus32.wdata_o}, 64'hFF00_FFFF);
        check("or_stall", 64'(bus32.stallreq_o), 64'd0);
        check("wd_pass", {59'h0, bus32.wd_o}, 64'd9);
        check("wreg_pass", 64'(bus32.wreg_o), 64'd1);
        check("hi_idle", get_hi(1'b0), 64'd0);
        apply(1'b0, EXE_AND_OP, EXE_RES_LOGIC, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        check("and", {32'h0, bus32.wdata_o}, 64'h00F0_00F0);
        apply(1'b0, EXE_XOR_OP, EXE_RES_LOGIC, 32'hFFFF_0000, 32'h0F0F_0F0F);
        check("xor", {32'h0, bus32.wdata_o}, 64'hF0F0_0F0F);
        apply(1'b0, EXE_NOR_OP, EXE_RES_LOGIC, 32'h0000_FFFF, 32'hFF00_0000);
        check("nor", {32'h0, bus32.wdata_o}, 64'h00FF_0000);
        apply(1'b0, EXE_OR_OP, EXE_RES_NOP, 32'h0000_FFFF, 32'hFF00_0000);
        check("class_nop", {32'h0, bus32.wdata_o}, 64'd0);
        apply(1'b0, EXE_SRA_OP, EXE_RES_SHIFT, 32'd4, 32'h8000_0000);
        check("sra4", {32'h0, bus32.wdata_o}, 64'hF800_0000);
        apply(1'b0, EXE_SRL_OP, EXE_RES_SHIFT, 32'd4, 32'h8000_0000);
        check("srl4", {32'h0, bus32.wdata_o}, 64'h0800_0000);
        apply(1'b0, EXE_SRA_OP, EXE_RES_SHIFT, 32'd0, 32'h8000_0000);
        check("sra0", {32'h0, bus32.wdata_o}, 64'h8000_0000);
        apply(1'b0, EXE_SLL_OP, EXE_RES_SHIFT, 32'h0000_0024, 32'h0000_00F1);
        check("sll_hi_bits_ignored", {32'h0, bus32.wdata_o}, 64'h0000_0F10);

        // Division results and latency
        apply(1'b0, EXE_DIV_OP, EXE_RES_NOP, 32'hFFFF_FFF9, 32'd2);
        wait_div(1'b0, 33, 64'hFFFF_FFFD, 64'hFFFF_FFFF, "div_m7_2");
        end_div(1'b0, "div_m7_2");
        apply(1'b0, EXE_DIV_OP, EXE_RES_NOP, 32'd100, 32'hFFFF_FFF9);
        wait_div(1'b0, 33, 64'hFFFF_FFF2, 64'd2, "div_100_m7");
        end_div(1'b0, "div_100_m7");
        apply(1'b0, EXE_DIVU_OP, EXE_RES_NOP, 32'd100, 32'd7);
        wait_div(1'b0, 33, 64'd14, 64'd2, "divu_100_7");
        @(negedge clk);
        #1;
        check("b2b_restart_stall", 64'(bus32.stallreq_o), 64'd1);
        wait_div(1'b0, 33, 64'd14, 64'd2, "divu_b2b");
        end_div(1'b0, "divu_b2b");
        apply(1'b0, EXE_DIVU_OP, EXE_RES_NOP, 32'd5, 32'd0);
        wait_div(1'b0, 33, 64'hFFFF_FFFF, 64'd5, "divu_5_0");
        end_div(1'b0, "divu_5_0");
        apply(1'b0, EXE_DIV_OP, EXE_RES_NOP, 32'hFFFF_FF9C, 32'd0);
        wait_div(1'b0, 33, 64'hFFFF_FFFF, 64'hFFFF_FF9C, "div_m100_0");
        end_div(1'b0, "div_m100_0");
        apply(1'b0, EXE_DIV_OP, EXE_RES_NOP, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_div(1'b0, 33, 64'h8000_0000, 64'd0, "div_minneg");
        end_div(1'b0, "div_minneg");

        // Flush in the middle of a division
        apply(1'b0, EXE_DIVU_OP, EXE_RES_NOP, 32'd1000, 32'd3);
        repeat (10) @(negedge clk);
        bus32.flush_i = 1'b1;
        #1;
        check("flush_stall", 64'(bus32.stallreq_o), 64'd0);
        check("flush_whilo", 64'(bus32.whilo_o), 64'd0);
        @(negedge clk);
        bus32.flush_i = 1'b0;
        drive(1'b0, EXE_NOP_OP, EXE_RES_NOP, 32'h0, 32'h0);
        #1;
        check("flush_idle_stall", 64'(bus32.stallreq_o), 64'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (bus32.whilo_o) pulses++;
        end
        check("flush_no_pulse", 64'(pulses), 64'd0);
        apply(1'b0, EXE_DIVU_OP, EXE_RES_NOP, 32'd9, 32'd3);
        wait_div(1'b0, 33, 64'd3, 64'd0, "divu_9_3");
        end_div(1'b0, "divu_9_3");

        // Reset asserted mid-division
        apply(1'b0, EXE_DIV_OP, EXE_RES_NOP, 32'hFFFF_FFF9, 32'd2);
        repeat (6) @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_stall", 64'(bus32.stallreq_o), 64'd0);
        drive(1'b0, EXE_NOP_OP, EXE_RES_NOP, 32'h0, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (bus32.whilo_o || bus32.stallreq_o) pulses++;
        end
        check("midrst_no_pulse", 64'(pulses), 64'd0);

        // 16-bit instance: same divisions, shorter latency
        apply(1'b1, EXE_DIV_OP, EXE_RES_NOP, 32'h0000_FFF9, 32'd2);
        wait_div(1'b1, 17, 64'hFFFD, 64'hFFFF, "w16_div_m7_2");
        end_div(1'b1, "w16_div_m7_2");
        apply(1'b1, EXE_DIVU_OP, EXE_RES_NOP, 32'd100, 32'd7);
        wait_div(1'b1, 17, 64'd14, 64'd2, "w16_divu_100_7");
        end_div(1'b1, "w16_divu_100_7");

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
